// File: rtl/gc_sched_pkg.sv
// Shared types for the two-core garbled-circuit stream scheduler.
package gc_sched_pkg;
  localparam int GC_S = 5;
  localparam int GC_K = 128;

  localparam logic [2:0] TAG_IDLE  = 3'b000;
  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;
  localparam int TAG_LABEL_BIT = 2;

  typedef enum logic [1:0] {
    KIND_LABEL = 2'b00,
    KIND_KEY   = 2'b01,
    KIND_TABLE = 2'b10,
    KIND_MASK  = 2'b11
  } out_kind_e;

  typedef struct packed {
    logic [2:0]      tag;
    logic [GC_S-1:0] idx0, idx1;
    logic [GC_K-1:0] d0, d1;
  } beat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_RUN, ST_FINISH} state_e;
endpackage

// File: rtl/gc_beat_fifo.sv
// Per-core beat FIFO; a push into a full FIFO is accepted only if a pop frees a slot the same cycle.
module gc_beat_fifo
  import gc_sched_pkg::*;
#(
  parameter int S     = GC_S,
  parameter int K     = GC_K,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  beat_t                    din,
  output beat_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 3 + 2*S + 2*K;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = beat_t'(mem[rd_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gc_stream_scheduler.sv
// Launches two garbling cores, buffers their beats and serializes them round-robin onto one ready/valid word link.
module gc_stream_scheduler
  import gc_sched_pkg::*;
#(
  parameter int S     = GC_S,
  parameter int K     = GC_K,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           gc_start,
  output logic [1:0]           gc_hold,
  output logic [1:0]           gc_ovf,
  input  logic [1:0][2:0]      tag_i,
  input  logic [1:0][S-1:0]    index0_i,
  input  logic [1:0][S-1:0]    index1_i,
  input  logic [1:0][K-1:0]    data0_i,
  input  logic [1:0][K-1:0]    data1_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_core,
  output logic [1:0]           out_kind,
  output logic [S-1:0]         out_index,
  output logic [K-1:0]         out_data,
  output logic                 out_last
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state, state_nxt;
  beat_t [1:0]         wr_beat, head;
  logic  [1:0]         push, pop, full, empty;
  logic  [1:0][CW-1:0] count;
  logic  [1:0]         core_done;
  logic                rr, lock, cur;

  for (genvar c = 0; c < 2; c++) begin : g_core
    assign push[c]    = (tag_i[c] != TAG_IDLE);
    assign wr_beat[c] = '{tag: tag_i[c], idx0: index0_i[c], idx1: index1_i[c],
                          d0: data0_i[c], d1: data1_i[c]};

    gc_beat_fifo #(.S(S), .K(K), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (wr_beat[c]),
      .dout  (head[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (count[c])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gc_hold[c] <= 1'b0;
        gc_ovf[c]  <= 1'b0;
      end else begin
        gc_hold[c] <= (count[c] >= CW'(DEPTH - 2));
        if (push[c] && full[c] && !pop[c]) gc_ovf[c] <= 1'b1;
      end
    end
  end

  // lock=1 means the first word of head[cur] is out and its second word is next
  logic          g, avail, can_load, adv, w_emit, w_end, w_last;
  out_kind_e     w_kind;
  logic [S-1:0]  w_idx;
  logic [K-1:0]  w_data;
  beat_t         hb;

  always_comb begin
    g        = lock ? cur : (empty[rr] ? !rr : rr);
    avail    = !empty[g];
    hb       = head[g];
    can_load = !out_valid || out_ready;
    adv      = avail && can_load;
    w_emit   = 1'b1;
    w_end    = 1'b1;
    w_last   = 1'b0;
    w_kind   = KIND_LABEL;
    w_idx    = '0;
    w_data   = '0;
    pop      = '0;
    if (hb.tag[TAG_LABEL_BIT]) begin
      if (!lock && hb.tag[0]) begin
        w_idx  = hb.idx0;
        w_data = hb.d0;
        w_end  = !hb.tag[1];
      end else begin
        // label with no valid halves drains without producing a word
        w_idx  = hb.idx1;
        w_data = hb.d1;
        w_emit = hb.tag[1];
      end
    end else begin
      case (hb.tag)
        TAG_KEY: begin
          w_kind = KIND_KEY;
          w_idx  = S'(lock);
          w_data = lock ? hb.d1 : hb.d0;
          w_end  = lock;
        end
        TAG_TABLE: begin
          w_kind = KIND_TABLE;
          w_idx  = lock ? hb.idx1 : hb.idx0;
          w_data = lock ? hb.d1 : hb.d0;
          w_end  = lock;
        end
        default: begin
          w_kind = KIND_MASK;
          w_data = hb.d0;
          w_last = 1'b1;
        end
      endcase
    end
    if (adv && w_end) pop[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_core  <= 1'b0;
      out_kind  <= '0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      lock      <= 1'b0;
      cur       <= 1'b0;
      rr        <= 1'b0;
    end else begin
      if (can_load) out_valid <= adv && w_emit;
      if (adv && w_emit) begin
        out_core  <= g;
        out_kind  <= w_kind;
        out_index <= w_idx;
        out_data  <= w_data;
        out_last  <= w_last;
      end
      if (adv) begin
        if (w_end) begin
          lock <= 1'b0;
          rr   <= !g;
        end else begin
          lock <= 1'b1;
          cur  <= g;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  core_done <= '0;
    else if (state == ST_LAUNCH)                 core_done <= '0;
    else if (out_valid && out_ready && out_last) core_done[out_core] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    gc_start  = '0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        busy      = 1'b1;
        gc_start  = 2'b11;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (&core_done && !out_valid) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_gc_stream_scheduler.sv
// Randomized and directed bench for gc_stream_scheduler with a per-core expected-word model.
module tb_gc_stream_scheduler;
  import gc_sched_pkg::*;
  localparam int S = 5;
  localparam int K = 128;
  localparam int DEPTH = 4;

  logic gclk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic busy, done, out_valid, out_core, out_last;
  logic [1:0] gc_start, gc_hold, gc_ovf, out_kind;
  logic [1:0][2:0]   tag_i;
  logic [1:0][S-1:0] index0_i, index1_i;
  logic [1:0][K-1:0] data0_i, data1_i;
  logic [S-1:0] out_index;
  logic [K-1:0] out_data;

  typedef struct packed {
    logic [1:0]   kind;
    logic [S-1:0] idx;
    logic [K-1:0] data;
    logic         last;
  } word_t;

  word_t expq[2][$];
  bit    log_core[$];
  int    n_chk = 0, n_fail = 0, n_xfer = 0, n_last = 0;
  bit    auto_model = 1'b1;
  bit    hold_prev = 1'b0;
  logic [136:0] prev;

  always #5 gclk = ~gclk;

  gc_stream_scheduler #(.S(S), .K(K), .DEPTH(DEPTH)) dut (
    .clk(gclk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .gc_start(gc_start), .gc_hold(gc_hold), .gc_ovf(gc_ovf),
    .tag_i(tag_i), .index0_i(index0_i), .index1_i(index1_i),
    .data0_i(data0_i), .data1_i(data1_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_core(out_core),
    .out_kind(out_kind), .out_index(out_index), .out_data(out_data), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // beat -> words, straight from the serialization rules
  task automatic exp_push(input int c, input logic [2:0] t, input logic [S-1:0] i0,
                          input logic [S-1:0] i1, input logic [K-1:0] d0, input logic [K-1:0] d1);
    if (t[2]) begin
      if (t[0]) expq[c].push_back(word_t'{2'd0, i0, d0, 1'b0});
      if (t[1]) expq[c].push_back(word_t'{2'd0, i1, d1, 1'b0});
    end else begin
      case (t[1:0])
        2'b01: begin
          expq[c].push_back(word_t'{2'd1, S'(0), d0, 1'b0});
          expq[c].push_back(word_t'{2'd1, S'(1), d1, 1'b0});
        end
        2'b10: begin
          expq[c].push_back(word_t'{2'd2, i0, d0, 1'b0});
          expq[c].push_back(word_t'{2'd2, i1, d1, 1'b0});
        end
        2'b11: expq[c].push_back(word_t'{2'd3, S'(0), d0, 1'b1});
        default: ;
      endcase
    end
  endtask

  always @(negedge gclk) begin
    if (!rst_n) hold_prev = 1'b0;
    else begin
      if (auto_model)
        for (int c = 0; c < 2; c++)
          if (tag_i[c] != 3'b000)
            exp_push(c, tag_i[c], index0_i[c], index1_i[c], data0_i[c], data1_i[c]);
      if (hold_prev)
        chk("stable", {out_valid, out_core, out_kind, out_index, out_data, out_last}, {1'b1, prev});
      if (out_valid && out_ready) begin
        n_xfer++;
        log_core.push_back(out_core);
        if (out_last) n_last++;
        chk("word_expected", expq[out_core].size() != 0, 1'b1);
        if (expq[out_core].size() != 0)
          chk("word", {out_kind, out_index, out_data, out_last}, expq[out_core].pop_front());
      end
      hold_prev = out_valid && !out_ready;
      prev = {out_core, out_kind, out_index, out_data, out_last};
    end
  end

  task automatic step();
    @(posedge gclk); #1;
  endtask

  task automatic smp();
    @(negedge gclk); #1;
  endtask

  task automatic drive(input int c, input logic [2:0] t, input logic [S-1:0] i0,
                       input logic [S-1:0] i1, input logic [K-1:0] d0, input logic [K-1:0] d1);
    tag_i[c] = t; index0_i[c] = i0; index1_i[c] = i1; data0_i[c] = d0; data1_i[c] = d1;
  endtask

  task automatic clear_in();
    tag_i = '0;
  endtask

  function automatic logic [K-1:0] rnd_k();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_xfer(input int target, input string name);
    for (int i = 0; i < 60 && n_xfer < target; i++) smp();
    repeat (3) smp();
    chk(name, n_xfer, target);
  endtask

  initial begin
    int base, cnt, c_old;
    logic [1:0] seen;
    logic [2:0] t;
    logic [K-1:0] kd [5];
    bit pushit;

    tag_i = '0; index0_i = '0; index1_i = '0; data0_i = '0; data1_i = '0;
    #3;
    chk("reset_outputs", {busy, done, gc_start, gc_hold, gc_ovf, out_valid, out_core,
                          out_kind, out_index, out_data, out_last}, '0);
    step(); step();
    rst_n = 1'b1;

    // launch, then a start while busy must be ignored
    step(); start = 1'b1;
    step(); start = 1'b0;
    smp();
    chk("launch_gc_start", gc_start, 2'b11);
    chk("launch_busy", busy, 1'b1);
    step(); smp();
    chk("gc_start_one_cycle", gc_start, 2'b00);
    chk("busy_run", busy, 1'b1);
    step(); start = 1'b1;
    step(); start = 1'b0;
    seen = '0;
    repeat (4) begin smp(); seen |= gc_start; end
    chk("restart_ignored", seen, 2'b00);

    // simultaneous key beats: core0 wins first after reset
    out_ready = 1'b1;
    base = n_xfer;
    step();
    drive(0, TAG_KEY, S'(4), S'(6), rnd_k(), rnd_k());
    drive(1, TAG_KEY, S'(8), S'(2), rnd_k(), rnd_k());
    step(); clear_in();
    wait_xfer(base + 4, "keys_count");
    if (log_core.size() >= base + 4)
      chk("keys_core_order", {log_core[base], log_core[base+1], log_core[base+2], log_core[base+3]}, 4'b0011);

    // single-half and double-half labels
    base = n_xfer;
    step();
    drive(0, 3'b101, S'(3), S'(7), {16{8'hA5}}, {16{8'h5A}});
    step(); clear_in();
    wait_xfer(base + 1, "label_half0_count");
    step();
    drive(0, 3'b111, S'(9), S'(17), rnd_k(), rnd_k());
    step(); clear_in();
    wait_xfer(base + 3, "label_both_count");

    // back-pressure: hold follows occupancy one edge late, no overflow
    out_ready = 1'b0;
    base = n_xfer;
    cnt = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      pushit = !gc_hold[1];
      if (pushit) drive(1, TAG_TABLE, S'($urandom), S'($urandom), rnd_k(), rnd_k());
      else clear_in();
      c_old = cnt;
      if (pushit) cnt++;
      step();
      chk("hold_lag", gc_hold[1], c_old >= 2);
    end
    clear_in();
    chk("hold_no_ovf", gc_ovf, 2'b00);
    out_ready = 1'b1;
    wait_xfer(base + 2*cnt, "hold_drain_count");

    // randomized traffic obeying gc_hold
    step();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!gc_hold[c] && $urandom_range(2) != 0) begin
          int r = $urandom_range(5);
          t = (r < 4) ? 3'(4 + r) : ((r == 4) ? TAG_KEY : TAG_TABLE);
          drive(c, t, S'($urandom), S'($urandom), rnd_k(), rnd_k());
        end else tag_i[c] = 3'b000;
      end
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    clear_in();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (expq[0].size() + expq[1].size()) != 0; i++) smp();
    chk("rand_drain_q0", expq[0].size(), 0);
    chk("rand_drain_q1", expq[1].size(), 0);
    chk("rand_no_ovf", gc_ovf, 2'b00);

    // overflow: 5 table beats into a 4-deep FIFO with the link stalled
    step();
    out_ready = 1'b0;
    auto_model = 1'b0;
    base = n_xfer;
    for (int i = 0; i < 5; i++) begin
      kd[i] = rnd_k();
      drive(1, TAG_TABLE, S'(i), S'(i + 16), kd[i], ~kd[i]);
      if (i < 4) exp_push(1, TAG_TABLE, S'(i), S'(i + 16), kd[i], ~kd[i]);
      step();
    end
    clear_in();
    auto_model = 1'b1;
    smp();
    chk("ovf_set", gc_ovf, 2'b10);
    step();
    out_ready = 1'b1;
    wait_xfer(base + 8, "ovf_drain_count");
    chk("ovf_sticky", gc_ovf, 2'b10);
    chk("ovf_model_empty", expq[1].size(), 0);

    // masks from both cores close the run
    step();
    drive(0, TAG_MASK, S'(0), S'(0), rnd_k(), rnd_k());
    drive(1, TAG_MASK, S'(0), S'(0), rnd_k(), rnd_k());
    step(); clear_in();
    for (int i = 0; i < 30 && n_last < 2; i++) smp();
    chk("masks_seen", n_last, 2);
    smp();
    chk("pre_done", {done, busy}, 2'b01);
    smp();
    chk("done_pulse", {done, busy}, 2'b10);
    smp();
    chk("after_done", {done, busy}, 2'b00);

    // reset in the middle of a stalled stream
    step(); start = 1'b1;
    step(); start = 1'b0;
    out_ready = 1'b0;
    drive(0, TAG_KEY, S'(1), S'(2), rnd_k(), rnd_k());
    drive(1, TAG_TABLE, S'(3), S'(4), rnd_k(), rnd_k());
    step();
    drive(0, TAG_TABLE, S'(5), S'(6), rnd_k(), rnd_k());
    step(); clear_in();
    step();
    chk("pre_reset_valid", {out_valid, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_state", {busy, done, gc_hold, gc_ovf}, '0);
    expq[0].delete();
    expq[1].delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_xfer;
    repeat (6) smp();
    chk("rst_fifos_empty", n_xfer, base);
    chk("rst_idle", {busy, out_valid, gc_hold}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
